uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a DEPTH-entry byte FIFO.
// A byte is accepted on i_valid && o_ready; the FSM pops the head of the
// FIFO into a shift register and serialises it LSB first. Frames run
// back-to-back when bytes are waiting.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 173,
    parameter int DEPTH        = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_tx,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and pointers
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_d;
    logic          push, pop;

    // Transmit datapath
    state_t        state, state_d;
    logic [7:0]    sh, sh_d;
    logic [2:0]    bit_idx, bit_d;
    logic [CW-1:0] baud, baud_d;
    logic          tx_d;
    logic          bit_end;

    assign push    = i_valid && o_ready;
    assign count_d = o_count + (AW+1)'(push) - (AW+1)'(pop);
    assign bit_end = (baud == BAUD_LAST);
    assign o_busy  = (state != IDLE) || (o_count != '0);

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            o_count <= count_d;
            o_ready <= (count_d != FULL_CNT);
        end
    end

    // FSM and transmit registers; o_tx is registered so the line never glitches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            o_tx    <= 1'b1;
            sh      <= '0;
            bit_idx <= '0;
            baud    <= '0;
        end else begin
            state   <= state_d;
            o_tx    <= tx_d;
            sh      <= sh_d;
            bit_idx <= bit_d;
            baud    <= baud_d;
        end
    end

    // Next-state logic: baud counter reloads at every bit boundary
    always_comb begin
        state_d = state;
        tx_d    = o_tx;
        sh_d    = sh;
        bit_d   = bit_idx;
        baud_d  = baud;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (o_count != '0) begin
                    pop     = 1'b1;
                    sh_d    = mem[rd_ptr];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = sh[0];
                    sh_d    = {1'b0, sh[7:1]};
                    state_d = DATA;
                end else begin
                    baud_d = baud + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                        tx_d  = sh[0];
                        sh_d  = {1'b0, sh[7:1]};
                    end
                end else begin
                    baud_d = baud + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (o_count != '0) begin
                        // Chain straight into the next start bit, no idle gap
                        pop     = 1'b1;
                        sh_d    = mem[rd_ptr];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timer reference model (queue of bytes plus
// elapsed-cycles-in-frame counter) is compared every cycle, a serial receiver
// decodes the line, and directed cases pin the model with literal values.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_ready, o_tx, o_busy;
    logic [2:0] o_count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_count(o_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];       // bytes waiting in the FIFO
    logic [7:0] exp_rx[$];   // bytes whose frames have started, in order
    logic [7:0] m_cur = 8'h00;
    bit         m_act = 1'b0;
    int         m_ft = 0;    // cycles elapsed in current frame
    bit         m_ready = 1'b0;
    bit         m_psh;
    logic [7:0] m_d;
    int         m_n;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            exp_rx.delete();
            m_act   = 1'b0;
            m_ft    = 0;
            m_ready = 1'b0;
        end else begin
            m_psh = i_valid && m_ready;
            m_d   = i_data;
            m_n   = mq.size();
            if (m_act) begin
                m_ft++;
                if (m_ft == 10*CPB) m_act = 1'b0;
            end
            if (!m_act && m_n > 0) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_ft  = 0;
                exp_rx.push_back(m_cur);
            end
            if (m_psh) mq.push_back(m_d);
            m_ready = (mq.size() != DEPTH);
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_ft / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_tx",    32'(o_tx),    32'(exp_tx()));
            chk("m_count", 32'(o_count), 32'(mq.size()));
            chk("m_ready", 32'(o_ready), 32'(m_ready));
            chk("m_busy",  32'(o_busy),  32'(m_act || mq.size() != 0));
        end
    end

    // ---------------- serial receiver (loopback) ----------------
    bit         rx_rst_seen = 1'b0;
    int         rx_good = 0;
    logic [7:0] rx_b;
    logic [7:0] rx_e;
    logic       rx_stop;
    logic       rx_startok;

    initial forever begin
        @(negedge rst_n);
        rx_rst_seen = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && o_tx === 1'b0) begin
            rx_rst_seen = 1'b0;
            repeat (CPB/2) @(negedge clk);
            rx_startok = (o_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rx_b[i] = o_tx;
            end
            repeat (CPB) @(negedge clk);
            rx_stop = o_tx;
            if (!rx_rst_seen) begin
                if (exp_rx.size() == 0) begin
                    chk("rx_extra_frame", 32'(rx_b), 32'hFFFF_FFFF);
                end else begin
                    rx_e = exp_rx.pop_front();
                    chk("rx_byte", 32'(rx_b), 32'(rx_e));
                    chk("rx_start", 32'(rx_startok), 32'd1);
                    chk("rx_stop", 32'(rx_stop), 32'd1);
                    rx_good++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge just after acceptance.
    task automatic push(input logic [7:0] b);
        int w = 0;
        i_valid = 1'b1;
        i_data  = b;
        while (!o_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w == 200) chk("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (o_busy && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w == 3000) chk("idle_timeout", 32'd1, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_ft(input int t);
        int w = 0;
        while (!(m_act && m_ft == t) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w == 500) chk("ft_timeout", 32'd1, 32'd0);
    endtask

    logic [39:0] exp41;
    logic [39:0] got41;
    int          bcnt;
    int          rx_before;

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(o_ready), 32'd1);

        // single byte 0x41: frame bits 0,1,0,0,0,0,0,1,0,1 each 4 cycles
        exp41 = '0;
        begin
            logic [9:0] fb;
            fb = 10'b1_0100_0001_0;   // stop, data msb..lsb, start (lsb = first)
            for (int i = 0; i < 40; i++) exp41[i] = fb[i/CPB];
        end
        push(8'h41);
        i_valid = 1'b0;
        chk("b41_tx_before_start", 32'(o_tx), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            got41[i] = o_tx;
        end
        chk("b41_wave", 32'(got41[31:0]), 32'(exp41[31:0]));
        chk("b41_wave_hi", 32'(got41[39:32]), 32'(exp41[39:32]));
        @(negedge clk);
        chk("b41_idle_tx", 32'(o_tx), 32'd1);
        chk("b41_busy_fall", 32'(o_busy), 32'd0);
        wait_idle();

        // back-to-back 0x55, 0xAA, 0x0D: busy stays up across all three frames
        push(8'h55);
        push(8'hAA);
        push(8'h0D);
        i_valid = 1'b0;
        bcnt = 0;
        while (o_busy && bcnt < 300) begin
            bcnt++;
            @(negedge clk);
        end
        chk("b2b_busy_cycles", 32'(bcnt), 32'd119);
        wait_idle();

        // full: 6 bytes held on i_valid during first frame
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        push(8'h05);
        chk("full_count", 32'(o_count), 32'd4);
        chk("full_ready", 32'(o_ready), 32'd0);
        push(8'h06);
        i_valid = 1'b0;
        wait_idle();

        // push+pop on the last STOP cycle with one byte queued
        push(8'h11);
        push(8'h22);
        i_valid = 1'b0;
        wait_ft(39);
        chk("pp_count_before", 32'(o_count), 32'd1);
        i_valid = 1'b1;
        i_data  = 8'h33;
        @(negedge clk);
        i_valid = 1'b0;
        chk("pp_count_after", 32'(o_count), 32'd1);
        chk("pp_start_now", 32'(o_tx), 32'd0);
        wait_idle();

        // reset mid-frame during DATA bit 3 of 0xC3 with two bytes queued
        push(8'hC3);
        push(8'h5A);
        push(8'h3C);
        i_valid = 1'b0;
        wait_ft(17);
        chk("mid_count_before", 32'(o_count), 32'd2);
        chk("mid_tx_bit3", 32'(o_tx), 32'd0);
        rx_before = rx_good;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(o_tx), 32'd1);
        chk("mid_rst_count", 32'(o_count), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("mid_no_frame", 32'(rx_good), 32'(rx_before));
        chk("mid_idle_busy", 32'(o_busy), 32'd0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            i_valid = ($urandom_range(0, 3) == 0);
            i_data  = 8'($urandom);
            @(negedge clk);
        end
        i_valid = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);
        chk("rx_all_delivered", 32'(exp_rx.size()), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
